// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
//   scan_state_t : scan FSM states (digit lit / inter-digit blanking gap)
//   nibble_vec_t : four display nibbles, index 0 = least significant digit
//   lz_blank()   : leading-zero test for the currently selected digit
package display_pkg;

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

  localparam int DIGIT_COUNT     = 4;
  localparam int DIGIT_SEL_WIDTH = 2;
  localparam int NIBBLE_WIDTH    = 4;
  localparam int WORD_WIDTH      = DIGIT_COUNT * NIBBLE_WIDTH;

  typedef logic [DIGIT_COUNT-1:0][NIBBLE_WIDTH-1:0] nibble_vec_t;

  // A digit is a leading zero when it and every more significant digit are
  // zero. Digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lz_blank(input nibble_vec_t shadow,
                                    input logic [DIGIT_SEL_WIDTH-1:0] sel);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (i >= int'(sel) && shadow[i] != '0) upper_zero = 1'b0;
    end
    return (sel != '0) && upper_zero;
  endfunction

endpackage

// File: rtl/display_scan_scheduler_dwell_timer.sv
// dwell_timer: free-running phase counter for the scan FSM.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : force count to 0 (scan frozen)
//   enable       : count this cycle
//   last         : terminal value, supplied at runtime (dwell or gap length - 1)
//   terminal     : high in the enabled cycle where count == last; the counter
//                  rolls back to 0 on that same edge
module dwell_timer #(
  parameter int TIMER_WIDTH = 17
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [TIMER_WIDTH-1:0] last,
  output logic                   terminal
);

  logic [TIMER_WIDTH-1:0] count;

  assign terminal = enable && (count == last);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + TIMER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: time-multiplexes the 4-digit seven-segment display.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   scanEnable        : 1 = scan runs; 0 = display blanked, scan frozen on digit
//   lzSuppress        : 1 = blank leading-zero digits (digit 0 always lit)
//   dataWord/Valid    : producer word, [3:0] = digit 0
//   dataReady         : word accepted when dataValid & dataReady
//   digitCounter      : digit select 0..3 for the segment controller
//   nibbleA..D        : tear-free shadow nibbles for digits 0..3
//   digitBlank        : force all digit enables off (registered)
//   frameTick         : one-cycle pulse the cycle digitCounter wraps 3 -> 0
// Each digit is lit for DWELL_CYCLES then blanked for GAP_CYCLES (anti-ghost).
// New words wait in a one-deep pending buffer and move to the shadow only at
// a frame boundary, so a frame never shows a mix of two words.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500,
  parameter int TIMER_WIDTH  = 17
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       scanEnable,
  input  logic                       lzSuppress,
  input  logic [WORD_WIDTH-1:0]      dataWord,
  input  logic                       dataValid,
  output logic                       dataReady,
  output logic [DIGIT_SEL_WIDTH-1:0] digitCounter,
  output logic [NIBBLE_WIDTH-1:0]    nibbleA,
  output logic [NIBBLE_WIDTH-1:0]    nibbleB,
  output logic [NIBBLE_WIDTH-1:0]    nibbleC,
  output logic [NIBBLE_WIDTH-1:0]    nibbleD,
  output logic                       digitBlank,
  output logic                       frameTick
);

  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [TIMER_WIDTH-1:0] DWELL_LAST = TIMER_WIDTH'(DWELL_CYCLES - 1);
  // With no gap the GAP limit is never selected; keep it a legal value.
  localparam logic [TIMER_WIDTH-1:0] GAP_LAST   =
    HAS_GAP ? TIMER_WIDTH'(GAP_CYCLES - 1) : '0;
  localparam logic [DIGIT_SEL_WIDTH-1:0] LAST_DIGIT =
    DIGIT_SEL_WIDTH'(DIGIT_COUNT - 1);

  scan_state_t             state;
  nibble_vec_t             shadow;
  nibble_vec_t             pending;
  logic                    pendingFull;
  logic [TIMER_WIDTH-1:0]  timer_last;
  logic                    timer_done;
  logic                    advance;
  logic                    frameBoundary;
  logic                    accept;

  assign timer_last = (state == GAP) ? GAP_LAST : DWELL_LAST;

  // Disabling the scan clears the timer so re-enable starts a full dwell.
  dwell_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (!scanEnable),
    .enable   (scanEnable),
    .last     (timer_last),
    .terminal (timer_done)
  );

  // Digit moves on at the end of the gap, or at the end of the dwell when
  // the design is built without a gap.
  assign advance       = timer_done && ((state == GAP) || !HAS_GAP);
  assign frameBoundary = advance && (digitCounter == LAST_DIGIT);

  // A full buffer frees up at the frame boundary, so a waiting word can be
  // taken in the same cycle the old one moves to the shadow.
  assign dataReady = !pendingFull || frameBoundary;
  assign accept    = dataValid && dataReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SHOW;
      digitCounter <= '0;
      shadow       <= '0;
      pending      <= '0;
      pendingFull  <= 1'b0;
      digitBlank   <= 1'b1;
      frameTick    <= 1'b0;
    end else begin
      frameTick  <= frameBoundary;
      digitBlank <= (state == GAP) || !scanEnable ||
                    (lzSuppress && lz_blank(shadow, digitCounter));

      if (!scanEnable) begin
        state <= SHOW;
      end else if (timer_done) begin
        state <= ((state == SHOW) && HAS_GAP) ? GAP : SHOW;
      end

      // Two-bit counter wraps 3 -> 0 on its own.
      if (advance) digitCounter <= digitCounter + DIGIT_SEL_WIDTH'(1);

      if (frameBoundary && pendingFull) shadow <= pending;

      if (accept) begin
        pending     <= nibble_vec_t'(dataWord);
        pendingFull <= 1'b1;
      end else if (frameBoundary) begin
        pendingFull <= 1'b0;
      end
    end
  end

  assign nibbleA = shadow[0];
  assign nibbleB = shadow[1];
  assign nibbleC = shadow[2];
  assign nibbleD = shadow[3];

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: one instance with a blanking gap and one
// built without, driven from the same inputs and each followed by a
// per-digit-period reference model.
module tb_display_scan_scheduler;

  localparam int DW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scanEnable = 1'b0;
  logic        lzSuppress = 1'b0;
  logic        dataValid = 1'b0;
  logic [15:0] dataWord = 16'h0;

  logic       rdy   [2];
  logic [1:0] dig   [2];
  logic [3:0] nA [2], nB [2], nC [2], nD [2];
  logic       blank [2];
  logic       ftick [2];

  always #5 clock = ~clock;

  display_scan_scheduler #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .TIMER_WIDTH(17)) u_dut (
    .clock(clock), .reset(reset), .scanEnable(scanEnable), .lzSuppress(lzSuppress),
    .dataWord(dataWord), .dataValid(dataValid), .dataReady(rdy[0]),
    .digitCounter(dig[0]), .nibbleA(nA[0]), .nibbleB(nB[0]), .nibbleC(nC[0]),
    .nibbleD(nD[0]), .digitBlank(blank[0]), .frameTick(ftick[0]));

  display_scan_scheduler #(.DWELL_CYCLES(4), .GAP_CYCLES(0), .TIMER_WIDTH(17)) u_dut_nogap (
    .clock(clock), .reset(reset), .scanEnable(scanEnable), .lzSuppress(lzSuppress),
    .dataWord(dataWord), .dataValid(dataValid), .dataReady(rdy[1]),
    .digitCounter(dig[1]), .nibbleA(nA[1]), .nibbleB(nB[1]), .nibbleC(nC[1]),
    .nibbleD(nD[1]), .digitBlank(blank[1]), .frameTick(ftick[1]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position inside the current digit period plus digit index.
  int          m_digit [2];
  int          m_ticks [2];
  logic [15:0] m_shadow[2];
  logic [15:0] m_pend  [2];
  bit          m_pf    [2];
  bit          m_blank [2];
  bit          m_ftick [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] shw(input int k);
    return {nD[k], nC[k], nB[k], nA[k]};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int p;
      bit bnd, rdy_e, acc;
      p     = DW + gap_of(k);
      bnd   = scanEnable && (m_ticks[k] == p - 1) && (m_digit[k] == 3);
      rdy_e = !m_pf[k] || bnd;
      if (!reset) chk("dataReady", k, 32'(rdy[k]), 32'(rdy_e));
      if (reset) begin
        m_digit[k] = 0; m_ticks[k] = 0; m_shadow[k] = '0; m_pend[k] = '0;
        m_pf[k] = 0; m_blank[k] = 1; m_ftick[k] = 0;
      end else begin
        acc = dataValid && rdy_e;
        m_blank[k] = (m_ticks[k] >= DW) || !scanEnable ||
                     (lzSuppress && m_digit[k] != 0 &&
                      (m_shadow[k] >> (4 * m_digit[k])) == 16'h0);
        m_ftick[k] = bnd;
        if (bnd && m_pf[k]) m_shadow[k] = m_pend[k];
        if (acc) begin
          m_pend[k] = dataWord; m_pf[k] = 1;
        end else if (bnd) begin
          m_pf[k] = 0;
        end
        if (!scanEnable) m_ticks[k] = 0;
        else if (m_ticks[k] == p - 1) begin
          m_ticks[k] = 0; m_digit[k] = (m_digit[k] + 1) % 4;
        end else m_ticks[k]++;
      end
    end
  endtask

  task automatic model_chk();
    for (int k = 0; k < 2; k++) begin
      chk("digitCounter", k, 32'(dig[k]),   32'(m_digit[k]));
      chk("nibbles",      k, 32'(shw(k)),   32'(m_shadow[k]));
      chk("digitBlank",   k, 32'(blank[k]), 32'(m_blank[k]));
      chk("frameTick",    k, 32'(ftick[k]), 32'(m_ftick[k]));
    end
  endtask

  task automatic cyc();
    #1;
    model_step();
    @(posedge clock);
    #1;
    model_chk();
  endtask

  task automatic wait_ftick(input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      cyc();
      if (ftick[0] === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL frameTick_wait no pulse within %0d cycles", lim);
    end
  endtask

  typedef struct {
    int cyc;
    int dig;  bit blank;  bit ftick;
    int dig0; bit blank0; bit ftick0;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, lit, nh, n2;
    bit found;

    // cycle after reset release, then {gap inst digit, blank, tick, nogap digit, blank, tick}
    tbl[0]  = '{0,  0, 1, 0, 0, 1, 0};
    tbl[1]  = '{1,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{4,  0, 0, 0, 1, 0, 0};
    tbl[3]  = '{5,  0, 1, 0, 1, 0, 0};
    tbl[4]  = '{6,  1, 1, 0, 1, 0, 0};
    tbl[5]  = '{7,  1, 0, 0, 1, 0, 0};
    tbl[6]  = '{11, 1, 1, 0, 2, 0, 0};
    tbl[7]  = '{12, 2, 1, 0, 3, 0, 0};
    tbl[8]  = '{16, 2, 0, 0, 0, 0, 1};
    tbl[9]  = '{18, 3, 1, 0, 0, 0, 0};
    tbl[10] = '{23, 3, 1, 0, 1, 0, 0};
    tbl[11] = '{24, 0, 1, 1, 2, 0, 0};
    tbl[12] = '{25, 0, 0, 0, 2, 0, 0};

    for (int k = 0; k < 2; k++) begin
      m_digit[k] = 0; m_ticks[k] = 0; m_shadow[k] = '0; m_pend[k] = '0;
      m_pf[k] = 0; m_blank[k] = 1; m_ftick[k] = 0;
    end

    // Reset, then free run against the table.
    reset = 1; scanEnable = 1;
    cyc(); cyc();
    reset = 0;
    ti = 0;
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) cyc();
      if (ti < 13 && tbl[ti].cyc == c) begin
        chk("tbl_digit",  0, 32'(dig[0]),   32'(tbl[ti].dig));
        chk("tbl_blank",  0, 32'(blank[0]), 32'(tbl[ti].blank));
        chk("tbl_ftick",  0, 32'(ftick[0]), 32'(tbl[ti].ftick));
        chk("tbl_digit",  1, 32'(dig[1]),   32'(tbl[ti].dig0));
        chk("tbl_blank",  1, 32'(blank[1]), 32'(tbl[ti].blank0));
        chk("tbl_ftick",  1, 32'(ftick[1]), 32'(tbl[ti].ftick0));
        ti++;
      end
    end

    // 0x1234 mid-frame: taken at once, shown only from the next frame start.
    dataWord = 16'h1234; dataValid = 1;
    #1 chk("ready_1234", 0, 32'(rdy[0]), 32'd1);
    cyc();
    dataValid = 0;
    chk("nib_before_wrap", 0, 32'(shw(0)), 32'h0);
    wait_ftick(40);
    chk("nib_1234", 0, 32'(shw(0)), 32'h1234);

    // 0xAAAA then 0xBBBB back-to-back: second waits for the frame boundary.
    dataWord = 16'hAAAA; dataValid = 1;
    cyc();
    dataWord = 16'hBBBB;
    #1 chk("ready_full", 0, 32'(rdy[0]), 32'd0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy[0] === 1'b1) begin found = 1; break; end
      cyc();
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL ready_wait dataReady never returned"); end
    cyc();
    dataValid = 0;
    chk("nib_aaaa", 0, 32'(shw(0)), 32'hAAAA);
    chk("tick_aaaa", 0, 32'(ftick[0]), 32'd1);
    wait_ftick(40);
    chk("nib_bbbb", 0, 32'(shw(0)), 32'hBBBB);

    // Leading-zero suppression with 0x0040, then 0x0000.
    dataWord = 16'h0040; dataValid = 1;
    cyc();
    dataValid = 0; lzSuppress = 1;
    wait_ftick(40);
    chk("nib_0040", 0, 32'(shw(0)), 32'h0040);
    lit = 0; nh = 0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) cyc();
      if (dig[0] >= 2) begin if (blank[0]) nh++; end
      else if (!blank[0]) lit++;
    end
    chk("lz40_hi_blank", 0, 32'(nh), 32'd12);
    chk("lz40_lo_lit", 0, 32'(lit), 32'd8);

    dataWord = 16'h0000; dataValid = 1;
    cyc();
    dataValid = 0;
    wait_ftick(40);
    chk("nib_0000", 0, 32'(shw(0)), 32'h0);
    lit = 0; nh = 0;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) cyc();
      if (!blank[0]) lit++;
      if (dig[0] != 0 && blank[0]) nh++;
    end
    chk("lz00_lit", 0, 32'(lit), 32'd4);
    chk("lz00_hi_blank", 0, 32'(nh), 32'd18);

    // scanEnable low for 10 clocks during digit 2.
    lzSuppress = 0;
    for (int i = 0; i < 40; i++) begin
      if (dig[0] == 2'd2) break;
      cyc();
    end
    cyc();
    scanEnable = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("frozen_digit", 0, 32'(dig[0]), 32'd2);
      chk("frozen_blank", 0, 32'(blank[0]), 32'd1);
      chk("frozen_tick", 0, 32'(ftick[0]), 32'd0);
    end
    scanEnable = 1;
    lit = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dig[0] != 2'd2) break;
      n2++;
      if (!blank[0]) lit++;
    end
    chk("reenable_lit", 0, 32'(lit), 32'd4);
    chk("reenable_span", 0, 32'(n2), 32'd5);

    // Reset during GAP with a word pending: the word is lost.
    dataWord = 16'hCAFE; dataValid = 1;
    cyc();
    dataValid = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_ticks[0] >= DW) break;
      cyc();
    end
    chk("ready_before_reset", 0, 32'(rdy[0]), 32'd0);
    reset = 1;
    cyc();
    chk("rst_digit", 0, 32'(dig[0]), 32'd0);
    chk("rst_nib", 0, 32'(shw(0)), 32'h0);
    chk("rst_blank", 0, 32'(blank[0]), 32'd1);
    chk("rst_tick", 0, 32'(ftick[0]), 32'd0);
    reset = 0;
    #1 chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
    wait_ftick(40);
    chk("rst_word_lost", 0, 32'(shw(0)), 32'h0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 63) == 0) scanEnable = ~scanEnable;
      if ($urandom_range(0, 31) == 0) lzSuppress = ~lzSuppress;
      dataValid  = ($urandom_range(0, 3) == 0);
      dataWord   = 16'($urandom) >> (4 * $urandom_range(0, 4));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
